// File: rtl/rr_arbiter8_pkg.sv
// Shared types, sizes and the rotate-priority winner search for the 8-way arbiter.
// Latency: none (types and a combinational helper only).
// Backpressure: not applicable.
package rr_arbiter8_pkg;

    localparam int NUM_REQ = 8;
    localparam int IDX_W   = 3;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } pick_t;

    // First set request bit scanning start, start+1, ... with wrap 7->0.
    // The scan runs from the far end back toward start, so the candidate
    // closest to start is the last one written and wins.
    function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] req,
                                      input logic [IDX_W-1:0]   start);
        pick_t            res;
        logic [IDX_W-1:0] cand;
        res = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = start + IDX_W'(k);
            if (req[cand]) begin
                res.found = 1'b1;
                res.idx   = cand;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_arbiter8_if.sv
// Requester-side bundle of the arbiter: request/enable/release in, grant status out.
// Latency: wires only.
// Backpressure: none; the grant itself is the flow-control answer to req.
interface rr_arbiter8_if;
    import rr_arbiter8_pkg::*;

    logic               en;
    logic [NUM_REQ-1:0] req;
    logic               done;
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_valid;
    logic               timeout;

    // Requester / resource-control side.
    modport master (
        output en, req, done,
        input  grant, grant_idx, grant_valid, timeout
    );

    // Arbiter side.
    modport slave (
        input  en, req, done,
        output grant, grant_idx, grant_valid, timeout
    );

endinterface

// File: rtl/rr_arbiter8_dec3to8.sv
// 3-to-8 one-hot decoder with enable; turns the registered owner index into the grant vector.
// Latency: combinational.
// Backpressure: none.
module rr_arbiter8_dec3to8
    import rr_arbiter8_pkg::*;
(
    input  logic [IDX_W-1:0]   w,
    input  logic               en,
    output logic [NUM_REQ-1:0] y
);

    // One output bit high for the selected index, all low when disabled.
    always_comb begin
        y = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            y[i] = en && (w == IDX_W'(i));
        end
    end

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin (or fixed-priority) arbiter for 8 requesters with a bounded hold time.
// Latency: grant visible right after the edge that samples req in IDLE; one idle cycle after each release.
// Backpressure: a requester waits while another owns the resource or while en is low.
module rr_arbiter8
    import rr_arbiter8_pkg::*;
#(
    parameter int MAX_HOLD   = 16,
    parameter int CNT_W      = 5,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic          clk,
    input  logic          rst_n,
    rr_arbiter8_if.slave  arb
);

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   grant_idx_q;
    logic               grant_valid_q;
    logic               timeout_q;
    logic [CNT_W-1:0]   hold_cnt;

    logic [IDX_W-1:0]   scan_start;
    pick_t              pick;
    logic               owner_req;
    logic               hold_expired;
    logic               release_now;
    logic               do_grant;
    logic               do_release;
    logic               expire_only;
    logic [NUM_REQ-1:0] grant_vec;

    // Fixed priority is just a scan that always starts at requester 0.
    assign scan_start   = FIXED_PRIO ? IDX_W'(0) : ptr;
    assign pick         = rr_pick(arb.req, scan_start);
    assign owner_req    = arb.req[grant_idx_q];
    assign hold_expired = (hold_cnt == CNT_W'(MAX_HOLD - 1));
    assign release_now  = arb.done || !owner_req || hold_expired;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: IDLE grants when allowed, HOLD always drops back to IDLE on release.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (arb.en && pick.found) state_nxt = S_HOLD;
            S_HOLD:  if (release_now)          state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM actions: when to load a new owner, when to drop it, and whether the drop
    // is purely a hold-time expiry (only that case raises the timeout pulse).
    always_comb begin
        do_grant    = 1'b0;
        do_release  = 1'b0;
        expire_only = 1'b0;
        case (state)
            S_IDLE: begin
                do_grant = arb.en && pick.found;
            end
            S_HOLD: begin
                do_release  = release_now;
                expire_only = hold_expired && !arb.done && owner_req;
            end
            default: begin
                do_release = 1'b1;
            end
        endcase
    end

    // Owner index, pointer, hold counter and timeout pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr           <= '0;
            grant_idx_q   <= '0;
            grant_valid_q <= 1'b0;
            hold_cnt      <= '0;
            timeout_q     <= 1'b0;
        end else begin
            timeout_q <= expire_only;
            if (do_grant) begin
                grant_idx_q   <= pick.idx;
                grant_valid_q <= 1'b1;
                hold_cnt      <= '0;
                ptr           <= pick.idx + IDX_W'(1);
            end else if (do_release) begin
                grant_valid_q <= 1'b0;
                hold_cnt      <= '0;
            end else if (state == S_HOLD) begin
                hold_cnt      <= hold_cnt + CNT_W'(1);
            end
        end
    end

    rr_arbiter8_dec3to8 u_dec (
        .w  (grant_idx_q),
        .en (grant_valid_q),
        .y  (grant_vec)
    );

    assign arb.grant       = grant_vec;
    assign arb.grant_idx   = grant_idx_q;
    assign arb.grant_valid = grant_valid_q;
    assign arb.timeout     = timeout_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Self-checking bench for rr_arbiter8: directed scenarios plus randomized traffic against a reference model.
// Latency: inputs driven on falling edges, outputs checked on the following falling edge.
// Backpressure: not applicable.
module tb_rr_arbiter8;

    localparam int MAX_HOLD = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: who owns the resource (-1 = nobody), how many grant
    // cycles it has been served, and where the next round-robin scan begins.
    int   m_owner   = -1;
    int   m_held    = 0;
    int   m_start   = 0;
    logic m_timeout = 1'b0;

    rr_arbiter8_if arb_if ();

    rr_arbiter8 #(
        .MAX_HOLD   (MAX_HOLD),
        .CNT_W      (5),
        .FIXED_PRIO (1'b0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .arb   (arb_if)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_owner   = -1;
        m_held    = 0;
        m_start   = 0;
        m_timeout = 1'b0;
    endtask

    task automatic model_edge();
        logic [7:0] r;
        int         w;
        r         = arb_if.req;
        m_timeout = 1'b0;
        if (m_owner < 0) begin
            if (arb_if.en && r != 8'h00) begin
                w = -1;
                for (int k = 0; k < 8; k++) begin
                    if (w < 0 && r[(m_start + k) % 8]) w = (m_start + k) % 8;
                end
                m_owner = w;
                m_held  = 1;
                m_start = (w + 1) % 8;
            end
        end else if (arb_if.done || !r[m_owner] || m_held >= MAX_HOLD) begin
            m_timeout = !arb_if.done && r[m_owner] && (m_held >= MAX_HOLD);
            m_owner   = -1;
        end else begin
            m_held++;
        end
    endtask

    function automatic logic [7:0] model_grant();
        return (m_owner < 0) ? 8'h00 : 8'(1 << m_owner);
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic do_reset();
        arb_if.en   = 1'b0;
        arb_if.req  = 8'h00;
        arb_if.done = 1'b0;
        rst_n       = 1'b0;
        #2;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        arb_if.en   = 1'b1;
        arb_if.req  = 8'hFF;
        arb_if.done = 1'b0;
        #1 rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (arb_if.grant !== 8'h00) $display("FAIL reset_grant: got %h want 00", arb_if.grant);
        else n_pass++;
        n_checks++;
        if (arb_if.grant_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", arb_if.grant_valid);
        else n_pass++;
        n_checks++;
        if (arb_if.timeout !== 1'b0) $display("FAIL reset_timeout: got %b want 0", arb_if.timeout);
        else n_pass++;
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (arb_if.grant !== 8'h01) $display("FAIL reset_first_grant: got %h want 01", arb_if.grant);
        else n_pass++;
        n_checks++;
        if (arb_if.grant_valid !== 1'b1 || arb_if.grant_idx !== 3'd0)
            $display("FAIL reset_first_idx: got valid=%b idx=%0d want valid=1 idx=0",
                     arb_if.grant_valid, arb_if.grant_idx);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        logic [7:0] exp;
        do_reset();
        arb_if.en   = 1'b1;
        arb_if.req  = 8'hFF;
        arb_if.done = 1'b1;
        for (int i = 0; i < 18; i++) begin
            tick();
            exp = (i % 2 == 0) ? 8'(1 << ((i / 2) % 8)) : 8'h00;
            n_checks++;
            if (arb_if.grant !== exp) $display("FAIL rr_order cycle %0d: got %h want %h", i, arb_if.grant, exp);
            else n_pass++;
        end
    endtask

    task automatic test_timeout();
        logic [7:0] exp_g;
        logic       exp_t;
        do_reset();
        arb_if.en   = 1'b1;
        arb_if.req  = 8'h04;
        arb_if.done = 1'b0;
        for (int i = 0; i < 18; i++) begin
            tick();
            exp_g = (i == MAX_HOLD) ? 8'h00 : 8'h04;
            exp_t = (i == MAX_HOLD);
            n_checks++;
            if (arb_if.grant !== exp_g) $display("FAIL hold_grant cycle %0d: got %h want %h", i, arb_if.grant, exp_g);
            else n_pass++;
            n_checks++;
            if (arb_if.timeout !== exp_t) $display("FAIL hold_timeout cycle %0d: got %b want %b", i, arb_if.timeout, exp_t);
            else n_pass++;
        end
    endtask

    task automatic test_wrap();
        do_reset();
        arb_if.en   = 1'b1;
        arb_if.done = 1'b0;
        arb_if.req  = 8'h40;
        tick();
        n_checks++;
        if (arb_if.grant !== 8'h40) $display("FAIL wrap_first: got %h want 40", arb_if.grant);
        else n_pass++;
        arb_if.done = 1'b1;
        tick();
        n_checks++;
        if (arb_if.grant !== 8'h00) $display("FAIL wrap_gap1: got %h want 00", arb_if.grant);
        else n_pass++;
        arb_if.done = 1'b0;
        arb_if.req  = 8'h41;
        tick();
        n_checks++;
        if (arb_if.grant !== 8'h01) $display("FAIL wrap_to_0: got %h want 01", arb_if.grant);
        else n_pass++;
        arb_if.done = 1'b1;
        tick();
        n_checks++;
        if (arb_if.grant !== 8'h00) $display("FAIL wrap_gap2: got %h want 00", arb_if.grant);
        else n_pass++;
        arb_if.done = 1'b0;
        tick();
        n_checks++;
        if (arb_if.grant !== 8'h40) $display("FAIL wrap_to_6: got %h want 40", arb_if.grant);
        else n_pass++;
    endtask

    task automatic test_en_hold();
        do_reset();
        arb_if.en   = 1'b1;
        arb_if.req  = 8'h02;
        arb_if.done = 1'b0;
        tick();
        arb_if.en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (arb_if.grant !== 8'h02) $display("FAIL en_hold_keep cycle %0d: got %h want 02", i, arb_if.grant);
            else n_pass++;
        end
        arb_if.done = 1'b1;
        tick();
        arb_if.done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (arb_if.grant !== 8'h00) $display("FAIL en_low_idle cycle %0d: got %h want 00", i, arb_if.grant);
            else n_pass++;
        end
        arb_if.en = 1'b1;
        tick();
        n_checks++;
        if (arb_if.grant !== 8'h02) $display("FAIL en_regrant: got %h want 02", arb_if.grant);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        do_reset();
        arb_if.en   = 1'b1;
        arb_if.req  = 8'h04;
        arb_if.done = 1'b0;
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if (arb_if.grant !== 8'h00 || arb_if.grant_valid !== 1'b0)
            $display("FAIL async_reset: got grant=%h valid=%b want 00/0", arb_if.grant, arb_if.grant_valid);
        else n_pass++;
        @(negedge clk);
        rst_n      = 1'b1;
        arb_if.req = 8'h0C;
        tick();
        n_checks++;
        if (arb_if.grant !== 8'h04) $display("FAIL async_ptr_cleared: got %h want 04", arb_if.grant);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [7:0] exp_g;
        do_reset();
        arb_if.en = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(7) == 0) arb_if.req = 8'($urandom);
            arb_if.en   = ($urandom_range(7) != 0);
            arb_if.done = ($urandom_range(15) == 0);
            tick();
            exp_g = model_grant();
            n_checks++;
            if (arb_if.grant !== exp_g) $display("FAIL rand_grant cycle %0d: got %h want %h", i, arb_if.grant, exp_g);
            else n_pass++;
            n_checks++;
            if (arb_if.grant_valid !== (m_owner >= 0))
                $display("FAIL rand_valid cycle %0d: got %b want %b", i, arb_if.grant_valid, (m_owner >= 0));
            else n_pass++;
            n_checks++;
            if (arb_if.timeout !== m_timeout) $display("FAIL rand_timeout cycle %0d: got %b want %b", i, arb_if.timeout, m_timeout);
            else n_pass++;
            if (m_owner >= 0) begin
                n_checks++;
                if (arb_if.grant_idx !== 3'(m_owner))
                    $display("FAIL rand_idx cycle %0d: got %0d want %0d", i, arb_if.grant_idx, m_owner);
                else n_pass++;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks so far %0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_round_robin();
        test_timeout();
        test_wrap();
        test_en_hold();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
